// File: rtl/fuzzy_pkg.sv
// Shared types for the fuzzy controller: Q1.15 value type, unity constant and the
// fuzzifier sequencing states.
package fuzzy_pkg;

  typedef logic [15:0] q15_t;

  localparam q15_t Q15_ONE = 16'h8000;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    T_EVAL = 2'd1,
    D_EVAL = 2'd2,
    OUT    = 2'd3
  } fsm_state_t;

  // Slope of a ramp that reaches 1.0 at |x| == span (span is a power of two).
  function automatic q15_t recip(input int span);
    return q15_t'(32768 / span);
  endfunction

endpackage

// File: rtl/fuzzifier_if.sv
// Sample-in / membership-out bus of the fuzzifier.
interface fuzzifier_if #(
  parameter int W_IN = 8
);
  import fuzzy_pkg::*;

  // Both directions use strict valid/ready: a transfer happens on a rising edge where
  // valid && ready; the producer keeps valid and its payload stable until that edge,
  // and the consumer may drive ready independently of valid.
  logic                   in_valid;
  logic                   in_ready;
  logic signed [W_IN-1:0] T_in;

  logic                   out_valid;
  logic                   out_ready;
  q15_t                   muT_neg;
  q15_t                   muT_zero;
  q15_t                   muT_pos;
  q15_t                   muD_neg;
  q15_t                   muD_zero;
  q15_t                   muD_pos;

  modport master (
    output in_valid, T_in, out_ready,
    input  in_ready, out_valid,
    input  muT_neg, muT_zero, muT_pos, muD_neg, muD_zero, muD_pos
  );

  modport slave (
    input  in_valid, T_in, out_ready,
    output in_ready, out_valid,
    output muT_neg, muT_zero, muT_pos, muD_neg, muD_zero, muD_pos
  );

endinterface

// File: rtl/tri_mf.sv
// Combinational neg/zero/pos membership evaluator for one signed crisp value.
module tri_mf
  import fuzzy_pkg::*;
#(
  parameter int W_X = 9
) (
  input  logic signed [W_X-1:0] x,
  input  q15_t                  recip_s,
  input  q15_t                  recip_z,
  output q15_t                  neg,
  output q15_t                  zero,
  output q15_t                  pos
);

  localparam int W_P = W_X + 16;

  logic [W_X-1:0] mag;
  logic [W_P-1:0] prod_s;
  logic [W_P-1:0] prod_z;
  q15_t           ramp_s;
  q15_t           ramp_z;

  function automatic q15_t sat(input logic [W_P-1:0] v);
    return (v > W_P'(Q15_ONE)) ? Q15_ONE : v[15:0];
  endfunction

  // Magnitude is taken one bit wider than the input range, so the most negative value is exact.
  always_comb begin
    mag    = x[W_X-1] ? $unsigned(-x) : $unsigned(x);
    prod_s = W_P'(mag) * W_P'(recip_s);
    prod_z = W_P'(mag) * W_P'(recip_z);
    ramp_s = sat(prod_s);
    ramp_z = sat(prod_z);
  end

  assign pos  = x[W_X-1] ? '0 : ramp_s;
  assign neg  = x[W_X-1] ? ramp_s : '0;
  assign zero = Q15_ONE - ramp_z;

endmodule

// File: rtl/fuzzifier.sv
// Crisp error stream to six Q1.15 memberships (T and its per-sample difference D).
// Optional macro FUZZ_DFILT_EN adds a two-tap averaging filter on D.
module fuzzifier
  import fuzzy_pkg::*;
#(
  parameter int W_IN      = 8,
  parameter int T_ZERO_HW = 16,
  parameter int T_SAT     = 32,
  parameter int D_ZERO_HW = 8,
  parameter int D_SAT     = 16
) (
  input  logic        clk,
  input  logic        rst,
  fuzzifier_if.slave  bus,
  output fsm_state_t  state_dbg
);

  localparam int   W_X  = W_IN + 1;
  localparam q15_t T_RS = recip(T_SAT);
  localparam q15_t T_RZ = recip(T_ZERO_HW);
  localparam q15_t D_RS = recip(D_SAT);
  localparam q15_t D_RZ = recip(D_ZERO_HW);

  fsm_state_t state;
  fsm_state_t state_next;

  logic signed [W_IN-1:0] t_reg;
  logic signed [W_IN-1:0] t_prev;
  logic                   first;
  logic signed [W_X-1:0]  d_reg;

  logic signed [W_X-1:0]  t_ext;
  logic signed [W_X-1:0]  prev_ext;
  logic signed [W_X-1:0]  d_raw;
  logic signed [W_X-1:0]  d_eff;

  logic signed [W_X-1:0]  mf_x;
  q15_t                   mf_rs;
  q15_t                   mf_rz;
  q15_t                   mf_neg;
  q15_t                   mf_zero;
  q15_t                   mf_pos;

  q15_t mu_t_neg, mu_t_zero, mu_t_pos;
  q15_t mu_d_neg, mu_d_zero, mu_d_pos;

  // ---------------------------------------------------------------- sequencing
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (bus.in_valid) state_next = T_EVAL;
      T_EVAL:  state_next = D_EVAL;
      D_EVAL:  state_next = OUT;
      OUT:     if (bus.out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = (state == OUT);
  assign state_dbg     = state;

  // ---------------------------------------------------------------- derivative
  always_comb begin
    t_ext    = {t_reg[W_IN-1], t_reg};
    prev_ext = {t_prev[W_IN-1], t_prev};
    d_raw    = first ? '0 : (t_ext - prev_ext);
  end

`ifdef FUZZ_DFILT_EN
  logic signed [W_X-1:0] d_f_prev;
  logic signed [W_X:0]   d_sum;

  // Averaging one bit wider, then dropping the LSB, is the arithmetic shift by one.
  always_comb begin
    d_sum = {d_raw[W_X-1], d_raw} + {d_f_prev[W_X-1], d_f_prev};
    d_eff = d_sum[W_X:1];
  end

  always_ff @(posedge clk) begin
    if (rst)                   d_f_prev <= '0;
    else if (state == D_EVAL)  d_f_prev <= d_reg;
  end
`else
  assign d_eff = d_raw;
`endif

  // ---------------------------------------------------------------- shared evaluator
  always_comb begin
    if (state == D_EVAL) begin
      mf_x  = d_reg;
      mf_rs = D_RS;
      mf_rz = D_RZ;
    end else begin
      mf_x  = t_ext;
      mf_rs = T_RS;
      mf_rz = T_RZ;
    end
  end

  tri_mf #(
    .W_X (W_X)
  ) u_mf (
    .x       (mf_x),
    .recip_s (mf_rs),
    .recip_z (mf_rz),
    .neg     (mf_neg),
    .zero    (mf_zero),
    .pos     (mf_pos)
  );

  // ---------------------------------------------------------------- datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      t_reg     <= '0;
      t_prev    <= '0;
      first     <= 1'b1;
      d_reg     <= '0;
      mu_t_neg  <= '0;
      mu_t_zero <= '0;
      mu_t_pos  <= '0;
      mu_d_neg  <= '0;
      mu_d_zero <= '0;
      mu_d_pos  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) t_reg <= bus.T_in;
        end
        T_EVAL: begin
          mu_t_neg  <= mf_neg;
          mu_t_zero <= mf_zero;
          mu_t_pos  <= mf_pos;
          d_reg     <= d_eff;
        end
        D_EVAL: begin
          mu_d_neg  <= mf_neg;
          mu_d_zero <= mf_zero;
          mu_d_pos  <= mf_pos;
          t_prev    <= t_reg;
          first     <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign bus.muT_neg  = mu_t_neg;
  assign bus.muT_zero = mu_t_zero;
  assign bus.muT_pos  = mu_t_pos;
  assign bus.muD_neg  = mu_d_neg;
  assign bus.muD_zero = mu_d_zero;
  assign bus.muD_pos  = mu_d_pos;

endmodule

// File: tb/tb_fuzzifier.sv
// Self-checking bench for fuzzifier: reference model feeds an expected queue at drive time.
module tb_fuzzifier;
  import fuzzy_pkg::*;

  localparam int W_IN = 8;
  localparam int T_Z  = 16;
  localparam int T_S  = 32;
  localparam int D_Z  = 8;
  localparam int D_S  = 16;

  // ---------------------------------------------------------------- clock / reset
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  fsm_state_t state_dbg;

  always #5 clk = ~clk;

  fuzzifier_if #(.W_IN(W_IN)) bus ();

  fuzzifier #(
    .W_IN      (W_IN),
    .T_ZERO_HW (T_Z),
    .T_SAT     (T_S),
    .D_ZERO_HW (D_Z),
    .D_SAT     (D_S)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus.slave),
    .state_dbg (state_dbg)
  );

  // ---------------------------------------------------------------- scoreboard
  int          n_checks = 0;
  int          n_errors = 0;
  logic [95:0] exp_q[$];
  int          m_prev;
  bit          m_first;
  int          m_dfp;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic int sat_q(input int v);
    return (v > 32768) ? 32768 : v;
  endfunction

  function automatic int mu_pos(input int x, input int s);
    return sat_q(((x > 0) ? x : 0) * (32768 / s));
  endfunction

  function automatic int mu_neg(input int x, input int s);
    return sat_q(((x < 0) ? -x : 0) * (32768 / s));
  endfunction

  function automatic int mu_zero(input int x, input int z);
    return 32768 - sat_q(((x < 0) ? -x : x) * (32768 / z));
  endfunction

  task automatic model_reset();
    m_prev  = 0;
    m_first = 1'b1;
    m_dfp   = 0;
  endtask

  task automatic model_push(input int t);
    int d;
    d = m_first ? 0 : (t - m_prev);
`ifdef FUZZ_DFILT_EN
    d     = (d + m_dfp) >>> 1;
    m_dfp = d;
`endif
    m_prev  = t;
    m_first = 1'b0;
    exp_q.push_back({16'(mu_neg(t, T_S)), 16'(mu_zero(t, T_Z)), 16'(mu_pos(t, T_S)),
                     16'(mu_neg(d, D_S)), 16'(mu_zero(d, D_Z)), 16'(mu_pos(d, D_S))});
  endtask

  // ---------------------------------------------------------------- driver tasks
  task automatic do_reset();
    @(negedge clk);
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_reset();
    exp_q.delete();
  endtask

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic send(input int t);
    int guard = 0;
    while (!bus.in_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    if (!bus.in_ready) check("in_ready_timeout", 32'(guard), 32'd0);
    bus.in_valid = 1'b1;
    bus.T_in     = W_IN'(t);
    model_push(t);
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_out(input string tag, input bit chk_lat);
    int lat = 1;
    while (!bus.out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    if (!bus.out_valid) check({tag, "_out_valid_timeout"}, 32'(bus.out_valid), 32'd1);
    else if (chk_lat) check({tag, "_latency"}, 32'(lat), 32'd3);
  endtask

  task automatic compare_mu(input string tag, input logic [95:0] e);
    check({tag, "_muT_neg"},  32'(bus.muT_neg),  32'(e[95:80]));
    check({tag, "_muT_zero"}, 32'(bus.muT_zero), 32'(e[79:64]));
    check({tag, "_muT_pos"},  32'(bus.muT_pos),  32'(e[63:48]));
    check({tag, "_muD_neg"},  32'(bus.muD_neg),  32'(e[47:32]));
    check({tag, "_muD_zero"}, 32'(bus.muD_zero), 32'(e[31:16]));
    check({tag, "_muD_pos"},  32'(bus.muD_pos),  32'(e[15:0]));
  endtask

  task automatic finish_out(input string tag);
    logic [95:0] e;
    if (exp_q.size() == 0) begin
      check({tag, "_queue_empty"}, 32'(exp_q.size()), 32'd1);
    end else begin
      e = exp_q.pop_front();
      compare_mu(tag, e);
    end
    bus.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.out_ready = 1'b0;
  endtask

  task automatic collect(input string tag);
    wait_out(tag, 1'b1);
    finish_out(tag);
  endtask

  // ---------------------------------------------------------------- stimulus
  initial begin
    int t;
    int dly;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.T_in      = '0;
    model_reset();

    // Reset state
    do_reset();
    check("rst_in_ready",  32'(bus.in_ready),  32'd1);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_state",     32'(state_dbg),     32'(IDLE));
    check("rst_muT_zero",  32'(bus.muT_zero),  32'd0);
    check("rst_muD_zero",  32'(bus.muD_zero),  32'd0);

    // T = 0, first sample
    send(0);
    wait_out("t0", 1'b1);
    check("t0_lit_muT_zero", 32'(bus.muT_zero), 32'h8000);
    check("t0_lit_muD_zero", 32'(bus.muD_zero), 32'h8000);
    finish_out("t0");

    // T = +8, D = +8
    send(8);
    wait_out("t8", 1'b1);
    check("t8_lit_muT_pos", 32'(bus.muT_pos), 32'h2000);
    check("t8_lit_muD_pos", 32'(bus.muD_pos), 32'h4000);
    finish_out("t8");

    // T = -128, D = -136
    send(-128);
    wait_out("tmin", 1'b1);
    check("tmin_lit_muT_neg", 32'(bus.muT_neg), 32'h8000);
    check("tmin_lit_muD_neg", 32'(bus.muD_neg), 32'h8000);
    finish_out("tmin");

    // Largest step: +127 after -128
    send(127);
    collect("tmax");

    // Back-pressure: output held, new sample refused until the handshake
    send(5);
    wait_out("hold", 1'b1);
    bus.in_valid = 1'b1;
    bus.T_in     = W_IN'(-20);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("hold_out_valid", 32'(bus.out_valid), 32'd1);
      check("hold_in_ready",  32'(bus.in_ready),  32'd0);
      check("hold_muT_pos",   32'(bus.muT_pos),   32'(exp_q[0][63:48]));
      check("hold_muD_pos",   32'(bus.muD_pos),   32'(exp_q[0][15:0]));
    end
    finish_out("hold");
    model_push(-20);
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    collect("held_sample");

    // Reset while the sample is in T_EVAL
    send(40);
    check("mid_state", 32'(state_dbg), 32'(T_EVAL));
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    exp_q.delete();
    for (int i = 0; i < 5; i++) begin
      check("mid_out_valid", 32'(bus.out_valid), 32'd0);
      @(negedge clk);
    end
    send(16);
    wait_out("after_rst", 1'b1);
    check("after_rst_lit_muD_zero", 32'(bus.muD_zero), 32'h8000);
    finish_out("after_rst");

    // D filter behaviour on a 0 -> 16 step
    do_reset();
    send(0);
    collect("filt0");
    send(16);
    wait_out("filt16", 1'b1);
`ifdef FUZZ_DFILT_EN
    check("filt16_lit_muD_pos", 32'(bus.muD_pos), 32'h4000);
`else
    check("filt16_lit_muD_pos", 32'(bus.muD_pos), 32'h8000);
`endif
    finish_out("filt16");

    // Random samples with random downstream stalls
    for (int i = 0; i < 20; i++) begin
      t   = $urandom_range(255);
      t   = t - 128;
      dly = $urandom_range(3);
      send(t);
      wait_out("rnd", 1'b1);
      repeat (dly) @(negedge clk);
      finish_out("rnd");
    end

    check("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", n_errors, n_checks);
    $fatal(1, "watchdog");
  end

endmodule
